// File: rtl/dpi_mailbox_pkg.sv
// Shared types and helpers for the host register mailbox.
package dpi_mailbox_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int          ID_REG       = 0;
    localparam logic [31:0] DEF_ID_VALUE = 32'hD91_0001;

    function automatic logic is_read_only(
        input logic [31:0] addr,
        input int          num_regs
    );
        return (addr == 32'(ID_REG)) ||
               (addr == 32'(num_regs - 1));
    endfunction

endpackage

// File: rtl/dpi_mailbox_regbank.sv
// Register array, free-running cycle counter and read mux.
module dpi_mailbox_regbank
    import dpi_mailbox_pkg::*;
#(
    parameter int          ADDR_W   = 4,
    parameter int          DATA_W   = 32,
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = DEF_ID_VALUE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         commit,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic                         err,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

    logic [DATA_W-1:0] rw_q [NUM_REGS];
    logic [DATA_W-1:0] view [NUM_REGS];
    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] rd_mux;
    logic              bad;
    logic              acc_err;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            view[i] = rw_q[i];
        end
        view[ID_REG]   = DATA_W'(ID_VALUE);
        view[NUM_REGS-1] = cnt_q;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = view[i];
        end
    end

    always_comb begin
        bad     = 32'(addr) >= 32'(NUM_REGS);
        acc_err = bad || (we && is_read_only(32'(addr), NUM_REGS));
        rd_mux  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_mux = view[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            rdata <= '0;
            err   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rw_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (commit) begin
                err   <= acc_err;
                rdata <= (acc_err || we) ? '0 : rd_mux;
                // read-only slots never hold writable state
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (we && !acc_err && addr == ADDR_W'(i)) begin
                        rw_q[i] <= wdata;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dpi_mailbox_responder.sv
// Host-facing req/ack mailbox: latches a request, waits, commits, acks.
module dpi_mailbox_responder
    import dpi_mailbox_pkg::*;
#(
    parameter int          ADDR_W   = 4,
    parameter int          DATA_W   = 32,
    parameter int          NUM_REGS = 8,
    parameter int          WAIT_CYC = 2,
    parameter logic [31:0] ID_VALUE = DEF_ID_VALUE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic                       ack,
    output logic [DATA_W-1:0]          rdata,
    output logic                       err,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr
);

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              ack_d;
    logic              load;
    logic              commit;
    logic              wr_ok;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    always_comb begin
        wr_ok = lat_we &&
                (32'(lat_addr) < 32'(NUM_REGS)) &&
                !is_read_only(32'(lat_addr), NUM_REGS);
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ack_d   = ack;
        load    = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    load    = 1'b1;
                    wcnt_d  = 4'(WAIT_CYC);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (wcnt_q == 4'd0) begin
                    commit  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            ack       <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ack     <= ack_d;
            wr_stb  <= commit && wr_ok;
            if (commit && wr_ok) begin
                wr_addr <= lat_addr;
            end
            if (load) begin
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end
        end
    end

    dpi_mailbox_regbank #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk       (clk),
        .rst       (rst),
        .commit    (commit),
        .we        (lat_we),
        .addr      (lat_addr),
        .wdata     (lat_wdata),
        .rdata     (rdata),
        .err       (err),
        .regs_flat (regs_flat)
    );

endmodule
